if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter and issues one-outstanding requests to the instruction memory/cache. It delivers instr/pc/pc+4 to the IF/ID pipeline register and absorbs hazard stalls, cache wait states and taken-branch redirects. Inserts NOP bubbles whenever no valid instruction is available, so IF/ID can always capture its outputs when not stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall from ID; IF/ID holds this cycle
- branch_taken_i  in  1  redirect request; priority over stall_i
- branch_target_i  in  32  redirect address; bits [1:0] forced to 0
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  request address; stable while imem_req_o high and imem_ready_i low
- imem_ready_i  in  1  request completes this cycle; imem_rdata_i valid
- imem_rdata_i  in  32  fetched word
- instr_o  out  32  instruction to IF/ID; NOP 32'h0000_0013 when valid_o=0
- pc_o  out  32  PC of instr_o
- pc_plus_o  out  32  pc_o + 4
- valid_o  out  1  instr_o is a real instruction

## Operation
- Registers: state, pc_q (next/current fetch PC), drop_addr_q, buf_q (32-bit held instruction).
- "Consumed" = valid_o & ~stall_i & ~branch_taken_i; every consume advances pc_q by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- States and outputs:
  - BOOT (reset state): req=0, valid_o=0. Next state is FETCH unconditionally. branch_taken_i loads pc_q.
  - FETCH: req=1, addr=pc_q. valid_o = imem_ready_i; instr_o = imem_rdata_i when valid.
    - branch & ready: data discarded (valid_o=0), pc_q<=target, stay FETCH.
    - branch & ~ready: drop_addr_q<=pc_q, pc_q<=target, go DROP.
    - ready & ~stall: consume, stay FETCH.
    - ready & stall: buf_q<=rdata, go HOLD.
    - ~ready: stay.
  - HOLD: req=0, valid_o=1, instr_o=buf_q.
    - branch: pc_q<=target, go FETCH, valid_o forced 0.
    - ~stall: consume, go FETCH.
    - stall: stay.
  - DROP: req=1, addr=drop_addr_q, valid_o=0.
    - ready: discard data, go FETCH.
    - branch: pc_q<=new target, remain per ready.
- pc_o=pc_q and pc_plus_o=pc_q+4 in all states; meaningful only when valid_o=1.
- Only one request is outstanding. The address never changes while a request is pending and unacknowledged.

## Timing
- Reset values (asynchronous, immediate): state=BOOT, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_o=NOP, valid_o=0, pc_o=RESET_PC, pc_plus_o=RESET_PC+4, buf_q=NOP.
- Reset asserted mid-request: the request is abandoned with no drain. Memory must tolerate req dropping.
- Zero-wait memory (ready same cycle as req): first valid_o in the 2nd cycle after rst_i release. One instruction per cycle thereafter.
- Memory latency of L wait cycles: valid_o asserted in the cycle ready rises. L bubbles per instruction.
- Taken branch in cycle N: bubble in N. Target instruction valid in N+1 when ready in N+1. In DROP: valid in the cycle after the stale ready, at the earliest.
- stall_i and branch_taken_i together: branch wins.
- valid_o, instr_o and pc outputs are combinational from state and memory inputs. No combinational path from stall_i/branch_taken_i to imem_* outputs.

## Structure
- Shared package fetch_pkg holds:
  - state enum (BOOT, FETCH, HOLD, DROP)
  - NOP_INSTR = 32'h0000_0013
  - PC_INCR = 4
  - XLEN = 32
- No sub-module. The next-PC mux and state machine stay inline in one module.

## Test plan
- Reset release with RESET_PC=0 and ready tied 1, words 0x11,0x22,0x33 at 0,4,8 -> cycle 1 bubble; cycles 2-4 valid_o=1 with pc_o 0,4,8 and instr_o 0x11,0x22,0x33.
- Stall: ready=1, stall_i high for 3 cycles on instr at pc 8 -> HOLD, imem_req_o=0, instr_o stays word@8. Stall release -> next cycle fetches pc 12.
- Wait states: ready low for 2 cycles at pc 4 -> imem_addr_o held at 4, valid_o=0 for 2 cycles, then valid with pc_o=4.
- Branch during pending miss: target 0x100 while the request at 0x10 is unready -> DROP keeps addr 0x10. The stale ready data is discarded. Next request addr=0x100, and the first valid pc_o=0x100.
- Branch + stall same cycle in HOLD, target 0x203 -> no instruction delivered. Next fetch addr 0x200.
- Wrap and async reset: pc 0xFFFFFFFC consumed -> pc_o becomes 0, pc_plus_o 4. Then assert rst_i mid-cycle -> all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC ownership, one-outstanding imem requests, bubbles
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            valid_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] drop_addr_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] target;
  logic            consume;

  assign target = align_word(branch_target_i);

  // Memory-side outputs depend on state only, so stall/branch never reach imem_*.
  always_comb begin
    imem_req_o  = (state_q == FETCH) || (state_q == DROP);
    imem_addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
  end

  always_comb begin
    valid_o = 1'b0;
    instr_o = NOP_INSTR;
    case (state_q)
      FETCH: begin
        valid_o = imem_ready_i & ~branch_taken_i;
        if (valid_o) instr_o = imem_rdata_i;
      end
      HOLD: begin
        valid_o = ~branch_taken_i;
        if (valid_o) instr_o = buf_q;
      end
      default: begin
        valid_o = 1'b0;
        instr_o = NOP_INSTR;
      end
    endcase
    pc_o      = pc_q;
    pc_plus_o = pc_q + PC_INCR;
  end

  // valid_o already excludes the branch cycle.
  assign consume = valid_o & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_q       <= NOP_INSTR;
    end else begin
      if (branch_taken_i) begin
        pc_q <= target;
      end else if (consume) begin
        pc_q <= pc_plus_o;
      end

      case (state_q)
        BOOT: state_q <= FETCH;
        FETCH: begin
          if (branch_taken_i) begin
            // An unacknowledged request must still be completed at its old address.
            if (!imem_ready_i) begin
              drop_addr_q <= pc_q;
              state_q     <= DROP;
            end
          end else if (imem_ready_i && stall_i) begin
            buf_q   <= imem_rdata_i;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (branch_taken_i || !stall_i) state_q <= FETCH;
        end
        DROP: begin
          if (imem_ready_i) state_q <= FETCH;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule
